// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, address-width helper and read-address type for the register file
package reg_file_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NRD = 2;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int DEF_AW = addr_w(DEF_DEPTH);
  typedef logic [DEF_NRD-1:0][DEF_AW-1:0] ra_arr_t;
endpackage

// File: rtl/mux_tree_np.sv
// mux_tree_np: DEPTH:1 selector built from levels of 2:1 muxes; level k is steered by sel_i[k]
module mux_tree_np
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
  input  logic [AW-1:0]               sel_i,
  output logic [WIDTH-1:0]            data_o
);
  for (genvar k = 0; k < AW; k++) begin : g_lvl
    logic [(DEPTH>>(k+1))-1:0][WIDTH-1:0] v;
    for (genvar j = 0; j < (DEPTH >> (k + 1)); j++) begin : g_mux
      if (k == 0) begin : g_in
        assign v[j] = sel_i[0] ? data_i[2*j+1] : data_i[2*j];
      end else begin : g_in
        assign v[j] = sel_i[k] ? g_lvl[k-1].v[2*j+1] : g_lvl[k-1].v[2*j];
      end
    end
  end
  assign data_o = g_lvl[AW-1].v[0];
endmodule

// File: rtl/reg_file_mux_np.sv
// reg_file_mux_np: register file with one write port and NRD mux-tree read ports, optional bypass and read register
module reg_file_mux_np
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD = DEF_NRD,
  parameter int REG_READ = 1,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 0,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       we,
  input  logic [AW-1:0]              wa,
  input  logic [WIDTH-1:0]           wd,
  input  logic [NRD-1:0]             re,
  input  logic [NRD-1:0][AW-1:0]     ra,
  output logic [NRD-1:0][WIDTH-1:0]  rd,
  output logic [NRD-1:0]             rvalid
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NRD < 1) begin : g_bad_cfg
    $fatal(1, "reg_file_mux_np: DEPTH must be a power of two >= 2 and NRD >= 1");
  end
  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        wr_ok;
  // Register 0 is never written when hardwired, so it always reads back as 0.
  assign wr_ok = we && !clear && !(ZERO_R0 != 0 && wa == '0);
  always_comb begin
    regs_d = regs_q;
    if (clear) regs_d = '0;
    else if (wr_ok) regs_d[wa] = wd;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else regs_q <= regs_d;
  end
  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [WIDTH-1:0] tree, sel;
    logic             byp;
    mux_tree_np #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
      .data_i(regs_q),
      .sel_i (ra[p]),
      .data_o(tree)
    );
    assign byp = (BYPASS != 0) && wr_ok && re[p] && ra[p] == wa;
    assign sel = byp ? wd : tree;
    if (REG_READ != 0) begin : g_reg
      logic [WIDTH-1:0] rd_q, rd_d;
      logic             rv_q;
      assign rd_d = re[p] ? sel : rd_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rd_q <= rd_d;
          rv_q <= re[p];
        end
      end
      assign rd[p] = rd_q;
      assign rvalid[p] = rv_q;
    end else begin : g_comb
      assign rd[p] = sel;
      assign rvalid[p] = re[p];
    end
  end
endmodule

// File: tb/tb_reg_file_mux_np.sv
// tb_reg_file_mux_np: vector table, directed corner sequences and random traffic against a memory-array model
module tb_reg_file_mux_np;
  import reg_file_pkg::*;
  logic clk, reset, clear, we;
  logic [2:0] wa;
  logic [3:0] wd;
  logic [1:0] re;
  ra_arr_t ra;
  logic [1:0][3:0] rd_a, rd_b;
  logic [1:0] rv_a, rv_b;
  logic [2:0] re3;
  logic [2:0][2:0] ra3;
  logic [2:0][3:0] rd_c;
  logic [2:0] rv_c;
  logic we_z;
  logic [3:0] wa_z;
  logic [7:0] wd_z;
  logic [1:0] re_z;
  logic [1:0][3:0] ra_z;
  logic [1:0][7:0] rd_z;
  logic [1:0] rv_z;
  int checks = 0;
  int errors = 0;

  reg_file_mux_np u_a (.clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa), .wd(wd),
                       .re(re), .ra(ra), .rd(rd_a), .rvalid(rv_a));
  reg_file_mux_np #(.BYPASS(0)) u_b (.clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa),
                       .wd(wd), .re(re), .ra(ra), .rd(rd_b), .rvalid(rv_b));
  reg_file_mux_np #(.NRD(3), .REG_READ(0)) u_c (.clk(clk), .reset(reset), .clear(clear), .we(we),
                       .wa(wa), .wd(wd), .re(re3), .ra(ra3), .rd(rd_c), .rvalid(rv_c));
  reg_file_mux_np #(.WIDTH(8), .DEPTH(16), .ZERO_R0(1)) u_z (.clk(clk), .reset(reset), .clear(clear),
                       .we(we_z), .wa(wa_z), .wd(wd_z), .re(re_z), .ra(ra_z), .rd(rd_z), .rvalid(rv_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic clr, we;
    logic [2:0] wa;
    logic [3:0] wd;
    logic [1:0] re;
    logic [2:0] ra0, ra1;
    logic [3:0] e0, e1, b0, b1;
    logic [1:0] ev;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int c, int w, int a, int d, int r, int r0, int r1,
                              int e0, int e1, int b0, int b1, int ev);
    vec_t v;
    v.clr = 1'(c); v.we = 1'(w); v.wa = 3'(a); v.wd = 4'(d); v.re = 2'(r);
    v.ra0 = 3'(r0); v.ra1 = 3'(r1); v.e0 = 4'(e0); v.e1 = 4'(e1);
    v.b0 = 4'(b0); v.b1 = 4'(b1); v.ev = 2'(ev);
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      re = 2'b11; ra[0] = 3'(i); ra[1] = 3'(7 - i);
      tick();
      chk($sformatf("%s rd0 a%0d", tag, i), 32'(rd_a[0]), 0);
      chk($sformatf("%s rd1 a%0d", tag, 7 - i), 32'(rd_a[1]), 0);
      chk($sformatf("%s rvalid", tag), 32'(rv_a), 3);
    end
    re = 2'b00;
  endtask

  logic [3:0] mem [8];
  logic [3:0] ea [2];
  logic [3:0] eb [2];
  logic [3:0] ex;

  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; wa = '0; wd = '0; re = '0; ra = '0;
    re3 = '0; ra3 = '0; we_z = 1'b0; wa_z = '0; wd_z = '0; re_z = '0; ra_z = '0;
    tick(); tick();
    chk("reset rd_a", 32'(rd_a), 0);
    chk("reset rv_a", 32'(rv_a), 0);
    chk("reset rd_b", 32'(rd_b), 0);
    chk("reset rv_b", 32'(rv_b), 0);
    chk("reset rd_z", 32'(rd_z), 0);
    chk("reset rv_z", 32'(rv_z), 0);
    reset = 1'b0;
    read_all_zero("post-reset");

    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, i, i + 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   3, 5, 7, 8,   10, 8,   10, 3));
    tbl.push_back(mk(0, 1, 2, 10,  0, 0, 0, 8,   10, 8,   10, 0));
    tbl.push_back(mk(0, 1, 2, 5,   1, 2, 0, 5,   10, 10,  10, 1));
    tbl.push_back(mk(0, 0, 0, 0,   3, 2, 3, 5,   6,  5,   6,  3));
    tbl.push_back(mk(1, 1, 3, 15,  0, 0, 0, 5,   6,  5,   6,  0));
    tbl.push_back(mk(0, 0, 0, 0,   3, 3, 7, 0,   0,  0,   0,  3));
    tbl.push_back(mk(0, 1, 4, 7,   0, 0, 0, 0,   0,  0,   0,  0));
    tbl.push_back(mk(1, 1, 4, 9,   1, 4, 0, 7,   0,  7,   0,  1));
    tbl.push_back(mk(0, 0, 0, 0,   1, 4, 0, 0,   0,  0,   0,  1));
    tbl.push_back(mk(0, 1, 6, 12,  0, 0, 0, 0,   0,  0,   0,  0));
    tbl.push_back(mk(0, 0, 0, 0,   3, 6, 6, 12,  12, 12,  12, 3));
    tbl.push_back(mk(0, 1, 6, 2,   3, 6, 6, 2,   2,  12,  12, 3));
    tbl.push_back(mk(0, 0, 0, 0,   2, 0, 6, 2,   2,  12,  2,  2));
    foreach (tbl[i]) begin
      clear = tbl[i].clr; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      re = tbl[i].re; ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
      tick();
      chk($sformatf("vec%0d rd_a0", i), 32'(rd_a[0]), 32'(tbl[i].e0));
      chk($sformatf("vec%0d rd_a1", i), 32'(rd_a[1]), 32'(tbl[i].e1));
      chk($sformatf("vec%0d rv_a", i), 32'(rv_a), 32'(tbl[i].ev));
      chk($sformatf("vec%0d rd_b0", i), 32'(rd_b[0]), 32'(tbl[i].b0));
      chk($sformatf("vec%0d rd_b1", i), 32'(rd_b[1]), 32'(tbl[i].b1));
      chk($sformatf("vec%0d rv_b", i), 32'(rv_b), 32'(tbl[i].ev));
    end
    clear = 1'b0; we = 1'b0;

    reset = 1'b1;
    #1;
    chk("async reset rd_a", 32'(rd_a), 0);
    chk("async reset rv_a", 32'(rv_a), 0);
    chk("async reset rd_b", 32'(rd_b), 0);
    chk("async reset rv_b", 32'(rv_b), 0);
    we = 1'b1; wa = 3'd1; wd = 4'hF; re = 2'b11;
    tick();
    chk("reset held rv_a", 32'(rv_a), 0);
    reset = 1'b0; we = 1'b0; re = 2'b00;
    read_all_zero("mid-reset");

    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int p = 0; p < 2; p++) begin ea[p] = '0; eb[p] = '0; end
    for (int c = 0; c < 300; c++) begin
      clear = ($urandom_range(15) == 0);
      we = 1'($urandom_range(1)); wa = 3'($urandom_range(7)); wd = 4'($urandom_range(15));
      re = 2'($urandom_range(3)); re3 = 3'($urandom_range(7));
      for (int p = 0; p < 2; p++) ra[p] = ($urandom_range(2) == 0) ? wa : 3'($urandom_range(7));
      for (int p = 0; p < 3; p++) ra3[p] = ($urandom_range(2) == 0) ? wa : 3'($urandom_range(7));
      #1;
      for (int p = 0; p < 3; p++) begin
        ex = (we && !clear && re3[p] && ra3[p] == wa) ? wd : mem[ra3[p]];
        chk($sformatf("rand%0d comb rd%0d", c, p), 32'(rd_c[p]), 32'(ex));
      end
      chk($sformatf("rand%0d comb rvalid", c), 32'(rv_c), 32'(re3));
      for (int p = 0; p < 2; p++) if (re[p]) begin
        ea[p] = (we && !clear && ra[p] == wa) ? wd : mem[ra[p]];
        eb[p] = mem[ra[p]];
      end
      if (clear) for (int i = 0; i < 8; i++) mem[i] = '0;
      else if (we) mem[wa] = wd;
      tick();
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rand%0d rd_a%0d", c, p), 32'(rd_a[p]), 32'(ea[p]));
        chk($sformatf("rand%0d rd_b%0d", c, p), 32'(rd_b[p]), 32'(eb[p]));
      end
      chk($sformatf("rand%0d rv_a", c), 32'(rv_a), 32'(re));
      chk($sformatf("rand%0d rv_b", c), 32'(rv_b), 32'(re));
    end
    clear = 1'b0; we = 1'b0; re = '0; re3 = '0;

    we = 1'b1; wa = 3'd6; wd = 4'hC;
    tick();
    we = 1'b0; re3 = 3'b111; ra3 = {3'd6, 3'd6, 3'd6};
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("comb same addr rd%0d", p), 32'(rd_c[p]), 32'hC);
    chk("comb rvalid on", 32'(rv_c), 32'h7);
    we = 1'b1; wa = 3'd6; wd = 4'h3;
    #1;
    for (int p = 0; p < 3; p++) chk($sformatf("comb bypass rd%0d", p), 32'(rd_c[p]), 32'h3);
    we = 1'b0; re3 = 3'b000;
    #1;
    chk("comb rvalid off", 32'(rv_c), 0);
    tick();

    we_z = 1'b1; wa_z = 4'd0; wd_z = 8'hFF;
    tick();
    wa_z = 4'd15; wd_z = 8'h81;
    tick();
    we_z = 1'b0; re_z = 2'b11; ra_z[0] = 4'd0; ra_z[1] = 4'd15;
    tick();
    chk("zero r0 read", 32'(rd_z[0]), 0);
    chk("zero addr15 read", 32'(rd_z[1]), 32'h81);
    chk("zero rvalid", 32'(rv_z), 3);
    we_z = 1'b1; wa_z = 4'd0; wd_z = 8'h55; re_z = 2'b01; ra_z[0] = 4'd0;
    tick();
    chk("zero r0 no bypass", 32'(rd_z[0]), 0);
    wa_z = 4'd15; wd_z = 8'h3C; re_z = 2'b10; ra_z[1] = 4'd15;
    tick();
    chk("zero addr15 bypass", 32'(rd_z[1]), 32'h3C);
    chk("zero port0 held", 32'(rd_z[0]), 0);
    wa_z = 4'd10; wd_z = 8'hA5; re_z = 2'b00;
    tick();
    we_z = 1'b0; re_z = 2'b01; ra_z[0] = 4'd10;
    tick();
    chk("zero addr10 read", 32'(rd_z[0]), 32'hA5);
    re_z = 2'b00;
    tick();
    chk("zero rvalid off", 32'(rv_z), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
